// File: rtl/simd_dotp_acc.sv
// Two-stage packed-SIMD dot product with a running accumulator.
// Stage 1 registers the lane products; stage 2 reduces them and commits the accumulator.
module simd_dotp_acc #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ELEN          = 8,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter bit          SATURATE      = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               op_i,
    input  logic                     sign_a_i,
    input  logic                     sign_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [XLEN-1:0]          operand_c_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     overflow_o
);

    localparam int unsigned LANES = XLEN / ELEN;
    localparam int unsigned PW    = 2 * ELEN + 2;
    localparam int unsigned SW    = XLEN + $clog2(LANES) + 2;

    typedef enum logic [1:0] {
        OP_DOTP     = 2'd0,
        OP_DOTP_ACC = 2'd1,
        OP_ACC_LOAD = 2'd2,
        OP_ACC_READ = 2'd3
    } op_e;

    logic                     advance;

    logic                     s1_valid_reg;
    op_e                      s1_op_reg;
    logic [XLEN-1:0]          s1_c_reg;
    logic [TRANS_ID_BITS-1:0] s1_tid_reg;
    logic signed [PW-1:0]     s1_prod_reg [LANES];
    logic signed [PW-1:0]     prod_next   [LANES];

    logic                     valid_reg;
    logic [XLEN-1:0]          result_reg;
    logic [TRANS_ID_BITS-1:0] tid_reg;
    logic                     ovf_reg;
    logic [XLEN-1:0]          acc_reg;

    logic signed [SW-1:0]     dot_sum;
    logic signed [SW-1:0]     addend;
    logic signed [SW-1:0]     final_sum;
    logic                     sum_ovf;
    logic [XLEN-1:0]          sum_res;
    logic [XLEN-1:0]          result_next;
    logic                     ovf_next;
    logic                     acc_we;

    assign advance    = ~valid_reg | ready_i;
    assign ready_o    = advance;
    assign valid_o    = valid_reg;
    assign result_o   = result_reg;
    assign trans_id_o = tid_reg;
    assign overflow_o = ovf_reg;

    // Each element widened by one bit so signed and unsigned lanes share one signed multiplier.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [ELEN:0] elem_a;
            logic signed [ELEN:0] elem_b;
            assign elem_a = {sign_a_i & operand_a_i[gi*ELEN+ELEN-1], operand_a_i[gi*ELEN +: ELEN]};
            assign elem_b = {sign_b_i & operand_b_i[gi*ELEN+ELEN-1], operand_b_i[gi*ELEN +: ELEN]};
            assign prod_next[gi] = PW'(elem_a) * PW'(elem_b);
        end
    endgenerate

    always_comb begin
        dot_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            dot_sum = dot_sum + SW'(s1_prod_reg[k]);
        end
        addend    = (s1_op_reg == OP_DOTP) ? SW'($signed(s1_c_reg)) : SW'($signed(acc_reg));
        final_sum = dot_sum + addend;
        // Fits in XLEN signed only when every bit from XLEN-1 upward agrees.
        sum_ovf   = ~((&final_sum[SW-1:XLEN-1]) | ~(|final_sum[SW-1:XLEN-1]));
        if (SATURATE && sum_ovf) begin
            sum_res = final_sum[SW-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
        end else begin
            sum_res = final_sum[XLEN-1:0];
        end

        result_next = sum_res;
        ovf_next    = sum_ovf;
        acc_we      = 1'b0;
        case (s1_op_reg)
            OP_DOTP_ACC: acc_we = 1'b1;
            OP_ACC_LOAD: begin
                result_next = s1_c_reg;
                ovf_next    = 1'b0;
                acc_we      = 1'b1;
            end
            OP_ACC_READ: begin
                result_next = acc_reg;
                ovf_next    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= OP_DOTP;
            s1_c_reg     <= '0;
            s1_tid_reg   <= '0;
            for (int k = 0; k < LANES; k++) begin
                s1_prod_reg[k] <= '0;
            end
            valid_reg    <= 1'b0;
            result_reg   <= '0;
            tid_reg      <= '0;
            ovf_reg      <= 1'b0;
            acc_reg      <= '0;
        end else if (flush_i) begin
            s1_valid_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else if (advance) begin
            s1_valid_reg <= valid_i;
            s1_op_reg    <= op_e'(op_i);
            s1_c_reg     <= operand_c_i;
            s1_tid_reg   <= trans_id_i;
            for (int k = 0; k < LANES; k++) begin
                s1_prod_reg[k] <= prod_next[k];
            end
            valid_reg    <= s1_valid_reg;
            if (s1_valid_reg) begin
                result_reg <= result_next;
                tid_reg    <= s1_tid_reg;
                ovf_reg    <= ovf_next;
                // Committing here lets the very next op in stage 1 see the new value.
                if (acc_we) begin
                    acc_reg <= result_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_dotp_acc.sv
// Bench for simd_dotp_acc: three configurations share one stimulus stream and are
// scored against an arithmetic model of the dot product and accumulator.
module tb_simd_dotp_acc;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        flush   = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [1:0]  op      = 2'd0;
    logic        sign_a  = 1'b0;
    logic        sign_b  = 1'b0;
    logic [2:0]  tid_i   = 3'd0;
    logic [31:0] a_i     = '0;
    logic [31:0] b_i     = '0;
    logic [31:0] c_i     = '0;

    logic [2:0]       valid_w;
    logic [2:0]       ready_w;
    logic [2:0]       ovf_w;
    logic [2:0][31:0] res_w;
    logic [2:0][2:0]  tid_w;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    localparam longint MAXV = 64'sh7FFFFFFF;
    localparam longint MINV = -64'sh80000000;

    always #5 clk = ~clk;

    // cfg0: ELEN=8 wrap, cfg1: ELEN=16 saturate, cfg2: ELEN=16 wrap
    simd_dotp_acc #(.XLEN(32), .ELEN(8), .TRANS_ID_BITS(3), .SATURATE(1'b0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_w[0]),
        .op_i(op), .sign_a_i(sign_a), .sign_b_i(sign_b), .trans_id_i(tid_i),
        .operand_a_i(a_i), .operand_b_i(b_i), .operand_c_i(c_i), .valid_o(valid_w[0]),
        .ready_i(ready_i), .result_o(res_w[0]), .trans_id_o(tid_w[0]), .overflow_o(ovf_w[0]));
    simd_dotp_acc #(.XLEN(32), .ELEN(16), .TRANS_ID_BITS(3), .SATURATE(1'b1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_w[1]),
        .op_i(op), .sign_a_i(sign_a), .sign_b_i(sign_b), .trans_id_i(tid_i),
        .operand_a_i(a_i), .operand_b_i(b_i), .operand_c_i(c_i), .valid_o(valid_w[1]),
        .ready_i(ready_i), .result_o(res_w[1]), .trans_id_o(tid_w[1]), .overflow_o(ovf_w[1]));
    simd_dotp_acc #(.XLEN(32), .ELEN(16), .TRANS_ID_BITS(3), .SATURATE(1'b0)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_w[2]),
        .op_i(op), .sign_a_i(sign_a), .sign_b_i(sign_b), .trans_id_i(tid_i),
        .operand_a_i(a_i), .operand_b_i(b_i), .operand_c_i(c_i), .valid_o(valid_w[2]),
        .ready_i(ready_i), .result_o(res_w[2]), .trans_id_o(tid_w[2]), .overflow_o(ovf_w[2]));

    typedef struct {
        logic [2:0]       tid;
        int               acc_cyc;
        logic [2:0][31:0] res;
        logic [2:0]       ovf;
        logic [2:0][31:0] acc_before;
    } pend_t;

    typedef struct {
        logic [2:0]       tid;
        int               lat;
        int               cyc;
        logic [2:0][31:0] res;
        logic [2:0]       ovf;
    } log_t;

    pend_t            pend_q[$];
    log_t             log_q[$];
    logic [2:0][31:0] macc = '0;

    function automatic longint dot_s(input logic [31:0] av, input logic [31:0] bv,
                                     input logic sa, input logic sb, input int elen);
        longint s    = 0;
        longint ua   = longint'(av);
        longint ub   = longint'(bv);
        longint mask = (longint'(1) << elen) - 1;
        longint ea;
        longint eb;
        for (int k = 0; k < 32 / elen; k++) begin
            ea = (ua >> (k * elen)) & mask;
            eb = (ub >> (k * elen)) & mask;
            if (sa && ea > (mask >> 1)) ea = ea - (mask + 1);
            if (sb && eb > (mask >> 1)) eb = eb - (mask + 1);
            s = s + ea * eb;
        end
        return s;
    endfunction

    function automatic void model_op(input int cfg, input logic [1:0] op_v,
                                     input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                                     input logic sa, input logic sb, inout logic [31:0] acc,
                                     output logic [31:0] res, output logic ovf);
        int     elen = (cfg == 0) ? 8 : 16;
        bit     sat  = (cfg == 1);
        longint f;
        res = '0;
        ovf = 1'b0;
        case (op_v)
            2'd0, 2'd1: begin
                f = dot_s(av, bv, sa, sb, elen) +
                    ((op_v == 2'd0) ? longint'($signed(cv)) : longint'($signed(acc)));
                ovf = (f > MAXV) || (f < MINV);
                if (sat && ovf) res = (f > 0) ? 32'h7FFFFFFF : 32'h80000000;
                else            res = f[31:0];
                if (op_v == 2'd1) acc = res;
            end
            2'd2: begin
                res = cv;
                acc = cv;
            end
            default: res = acc;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Scoreboard: any presented result must match the oldest outstanding request.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend_q.delete();
            macc = '0;
        end else begin
            if (valid_w != 3'b000) begin
                if (pend_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: valid_o=%b with no request outstanding", valid_w);
                end else begin
                    for (int c = 0; c < 3; c++) begin
                        checks++;
                        if (valid_w[c] !== 1'b1 || res_w[c] !== pend_q[0].res[c] ||
                            ovf_w[c] !== pend_q[0].ovf[c] || tid_w[c] !== pend_q[0].tid) begin
                            errors++;
                            $display("FAIL result_cfg%0d: got v=%b res=%h ovf=%b tid=%0d, expected res=%h ovf=%b tid=%0d",
                                     c, valid_w[c], res_w[c], ovf_w[c], tid_w[c],
                                     pend_q[0].res[c], pend_q[0].ovf[c], pend_q[0].tid);
                        end
                    end
                    if (ready_i) begin
                        log_t e;
                        e.tid = tid_w[0];
                        e.lat = cycle - pend_q[0].acc_cyc;
                        e.cyc = cycle;
                        e.res = res_w;
                        e.ovf = ovf_w;
                        log_q.push_back(e);
                        $display("cyc %0d: result tid=%0d res=%h/%h/%h ovf=%b lat=%0d",
                                 cycle, e.tid, e.res[0], e.res[1], e.res[2], e.ovf, e.lat);
                        void'(pend_q.pop_front());
                    end
                end
            end
            if (flush) begin
                if (pend_q.size() > 0) macc = pend_q[0].acc_before;
                pend_q.delete();
            end else if (valid_i && ready_w[0]) begin
                pend_t       p;
                logic [31:0] acc_t;
                logic [31:0] r;
                logic        o;
                p.tid     = tid_i;
                p.acc_cyc = cycle;
                for (int c = 0; c < 3; c++) begin
                    acc_t           = macc[c];
                    p.acc_before[c] = acc_t;
                    model_op(c, op, a_i, b_i, c_i, sign_a, sign_b, acc_t, r, o);
                    macc[c]  = acc_t;
                    p.res[c] = r;
                    p.ovf[c] = o;
                end
                pend_q.push_back(p);
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic sa, input logic sb, input logic [2:0] t,
                        input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
        bit done = 1'b0;
        op = o; sign_a = sa; sign_b = sb; tid_i = t; a_i = av; b_i = bv; c_i = cv;
        valid_i = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = ready_w[0] && !flush;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: request tid=%0d not accepted, required acceptance within 100 cycles", t);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && pend_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (pend_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", pend_q.size());
        end
    endtask

    task automatic test_reset();
        int c0;
        int n0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (valid_w !== 3'b000 || ready_w !== 3'b111) begin
            errors++;
            $display("FAIL reset_handshake: valid_o=%b ready_o=%b, required 000/111", valid_w, ready_w);
        end
        checks++;
        if (res_w !== '0 || tid_w !== '0 || ovf_w !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: result=%h tid=%h ovf=%b, required all zero", res_w, tid_w, ovf_w);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        c0 = cycle;
        n0 = log_q.size();
        send(2'd3, 1'b0, 1'b0, 3'd7, '0, '0, '0);
        checks++;
        if (cycle - c0 != 1) begin
            errors++;
            $display("FAIL first_accept: accepted after %0d edges, required 1", cycle - c0);
        end
        drain();
        checks++;
        if (log_q.size() != n0 + 1 || log_q[n0].res !== '0 || log_q[n0].lat != 2) begin
            errors++;
            $display("FAIL reset_acc: entries=%0d, required %0d with acc 0 at latency 2", log_q.size() - n0, 1);
        end
    endtask

    task automatic test_dotp_latency();
        send(2'd0, 1'b0, 1'b1, 3'd1, 32'hFFFFFFFF, 32'h01FF01FF, 32'd10);
        checks++;
        if (valid_w !== 3'b000) begin
            errors++;
            $display("FAIL latency_early: valid_o=%b one edge after acceptance, required 000", valid_w);
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_w !== 3'b111 || res_w[0] !== 32'd10 || ovf_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL dotp_basic: valid_o=%b result=%h ovf=%b, required 111/0000000a/0", valid_w, res_w[0], ovf_w[0]);
        end
        drain();
    endtask

    task automatic test_acc_sequence();
        logic [31:0] exp_v [4];
        int          n0 = log_q.size();
        exp_v = '{32'd5, 32'd13, 32'd21, 32'd21};
        send(2'd2, 1'b0, 1'b0, 3'd2, '0, '0, 32'd5);
        send(2'd1, 1'b1, 1'b1, 3'd3, 32'h01010101, 32'h02020202, '0);
        send(2'd1, 1'b1, 1'b1, 3'd4, 32'h01010101, 32'h02020202, '0);
        send(2'd3, 1'b0, 1'b0, 3'd5, '0, '0, '0);
        drain();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_q.size() < n0 + 4) begin
                errors++;
                $display("FAIL acc_seq_count: got %0d results, required 4", log_q.size() - n0);
                break;
            end
            if (log_q[n0+i].res[0] !== exp_v[i] || log_q[n0+i].lat != 2 ||
                (i > 0 && log_q[n0+i].cyc - log_q[n0+i-1].cyc != 1)) begin
                errors++;
                $display("FAIL acc_seq%0d: result=%h lat=%0d, required %h lat=2 on consecutive cycles",
                         i, log_q[n0+i].res[0], log_q[n0+i].lat, exp_v[i]);
            end
        end
    endtask

    task automatic test_stall();
        int n0 = log_q.size();
        send(2'd1, 1'b1, 1'b0, 3'd1, $urandom, $urandom, '0);
        send(2'd1, 1'b0, 1'b1, 3'd2, $urandom, $urandom, '0);
        ready_i = 1'b0;
        op = 2'd3; tid_i = 3'd3; valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ready_w !== 3'b000 || valid_w !== 3'b111 || tid_w[0] !== 3'd1) begin
                errors++;
                $display("FAIL stall_hold%0d: ready_o=%b valid_o=%b tid=%0d, required 000/111/1", i, ready_w, valid_w, tid_w[0]);
            end
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        send(2'd3, 1'b0, 1'b0, 3'd3, '0, '0, '0);
        drain();
        checks++;
        if (log_q.size() != n0 + 3 || log_q[n0].tid !== 3'd1 || log_q[n0+1].tid !== 3'd2 || log_q[n0+2].tid !== 3'd3) begin
            errors++;
            $display("FAIL stall_order: got %0d results, required 3 with tids 1,2,3", log_q.size() - n0);
        end
    endtask

    task automatic test_saturate();
        int n0 = log_q.size();
        send(2'd2, 1'b0, 1'b0, 3'd0, '0, '0, 32'h7FFFFFF0);
        send(2'd1, 1'b0, 1'b0, 3'd1, 32'h00320032, 32'h00010001, '0);
        send(2'd3, 1'b0, 1'b0, 3'd2, '0, '0, '0);
        drain();
        checks++;
        if (log_q.size() != n0 + 3) begin
            errors++;
            $display("FAIL sat_count: got %0d results, required 3", log_q.size() - n0);
        end else begin
            if (log_q[n0+1].res[1] !== 32'h7FFFFFFF || log_q[n0+1].ovf[1] !== 1'b1) begin
                errors++;
                $display("FAIL sat_clamp: result=%h ovf=%b, required 7fffffff/1", log_q[n0+1].res[1], log_q[n0+1].ovf[1]);
            end
            checks++;
            if (log_q[n0+1].res[0] !== 32'h7FFFFFF0 + 32'd100 || log_q[n0+1].ovf[0] !== 1'b1) begin
                errors++;
                $display("FAIL sat_wrap: result=%h ovf=%b, required %h/1", log_q[n0+1].res[0], log_q[n0+1].ovf[0], 32'h7FFFFFF0 + 32'd100);
            end
            checks++;
            if (log_q[n0+2].res[1] !== 32'h7FFFFFFF || log_q[n0+2].ovf !== 3'b000) begin
                errors++;
                $display("FAIL sat_read: result=%h ovf=%b, required 7fffffff/000", log_q[n0+2].res[1], log_q[n0+2].ovf);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] x = $urandom;
        int          n0;
        send(2'd2, 1'b0, 1'b0, 3'd1, '0, '0, x);
        drain();
        n0 = log_q.size();
        send(2'd1, 1'b1, 1'b1, 3'd2, $urandom, $urandom, '0);
        flush = 1'b1;
        op = 2'd0; tid_i = 3'd3; a_i = $urandom; valid_i = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid_w !== 3'b000) begin
                errors++;
                $display("FAIL flush_valid%0d: valid_o=%b after flush, required 000", i, valid_w);
            end
            @(posedge clk);
            #1;
        end
        send(2'd3, 1'b0, 1'b0, 3'd4, '0, '0, '0);
        drain();
        checks++;
        if (log_q.size() != n0 + 1 || log_q[n0].res !== {x, x, x} || log_q[n0].tid !== 3'd4) begin
            errors++;
            $display("FAIL flush_acc: got %0d results, required 1 with acc %h tid 4", log_q.size() - n0, x);
        end
    endtask

    task automatic test_elen16();
        int n0 = log_q.size();
        send(2'd0, 1'b1, 1'b1, 3'd5, 32'h80008000, 32'h80008000, '0);
        drain();
        checks++;
        if (log_q.size() != n0 + 1 || log_q[n0].res[2] !== 32'h80000000 || log_q[n0].ovf[2] !== 1'b1 ||
            log_q[n0].res[1] !== 32'h7FFFFFFF || log_q[n0].ovf[1] !== 1'b1 ||
            log_q[n0].res[0] !== 32'd32768 || log_q[n0].ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL elen16_min: got %0d results, required 80000000/1, 7fffffff/1, 00008000/0", log_q.size() - n0);
        end
    endtask

    task automatic test_mid_reset();
        int n0 = log_q.size();
        send(2'd1, 1'b1, 1'b1, 3'd1, $urandom, $urandom, '0);
        send(2'd1, 1'b1, 1'b1, 3'd2, $urandom, $urandom, '0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_w !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: valid_o=%b during reset, required 000", valid_w);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_w !== 3'b000) begin
                errors++;
                $display("FAIL reset_discard%0d: valid_o=%b after release, required 000", i, valid_w);
            end
            @(posedge clk);
            #1;
        end
        send(2'd3, 1'b0, 1'b0, 3'd6, '0, '0, '0);
        drain();
        checks++;
        if (log_q.size() != n0 + 1 || log_q[n0].res !== '0) begin
            errors++;
            $display("FAIL reset_midop: got %0d results, required 1 reading acc 0", log_q.size() - n0);
        end
    endtask

    task automatic test_random();
        int n0   = log_q.size();
        bit stop = 1'b0;
        fork
            while (!stop) begin
                @(posedge clk);
                #1;
                ready_i = ($urandom_range(0, 3) != 0);
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                stop = 1'b1;
            end
        join
        ready_i = 1'b1;
        drain();
        checks++;
        if (log_q.size() != n0 + 300) begin
            errors++;
            $display("FAIL random_count: got %0d results, required 300", log_q.size() - n0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_dotp_latency();
        test_acc_sequence();
        test_stall();
        test_saturate();
        test_flush();
        test_elen16();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
